// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select codes and the pipeline slot record shared by hazard_ctrl and hazard_match
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } slot_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one source register against one pipeline slot
//   slot     : tracked older instruction {valid, rd, we, is_load}
//   used     : the source operand is actually read
//   addr     : source register index
//   hit      : slot produces the value the operand needs (x0 never matches)
//   load_hit : hit where the producer is a load (data not ready for ALU forward)
module hazard_match
    import hazard_pkg::*;
(
    input  slot_t      slot,
    input  logic       used,
    input  logic [4:0] addr,
    output logic       hit,
    output logic       load_hit
);
    always_comb begin
        hit      = used & slot.valid & slot.we & (slot.rd == addr) & (addr != 5'd0);
        load_hit = hit & slot.is_load;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and EX-stage forwarding-select generation for a 5-stage pipeline
//   clk, rst                   : clock, synchronous active-high reset
//   id_*                       : decode-stage instruction fields
//   flush                      : squash the decode-stage instruction
//   hold                       : freeze all hazard state (memory wait); wins over flush
//   rs1_hazard, rs2_hazard     : registered operand selects (FWD_RF / FWD_ALU / FWD_MEM)
//   stall                      : combinational load-use stall of PC and IF/ID
//   ex_bubble                  : registered, EX holds no valid instruction
//   stall_cnt                  : stalled non-held cycle counter, present only with HAZARD_PERF_EN
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       id_rd_we,
    input  logic       id_is_load,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic [4:0] id_rd_addr,
    input  logic       flush,
    input  logic       hold,
    output logic [1:0] rs1_hazard,
    output logic [1:0] rs2_hazard,
    output logic       stall,
    output logic       ex_bubble
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    slot_t      d1, d2, id_slot;
    logic       rs1_d1, rs2_d1, rs1_d2, rs2_d2, rs1_ld1, rs2_ld1;
    logic       advance;
    logic [1:0] rs1_sel, rs2_sel;

    hazard_match u_rs1_d1 (.slot(d1), .used(id_rs1_used), .addr(id_rs1_addr), .hit(rs1_d1), .load_hit(rs1_ld1));
    hazard_match u_rs2_d1 (.slot(d1), .used(id_rs2_used), .addr(id_rs2_addr), .hit(rs2_d1), .load_hit(rs2_ld1));
    hazard_match u_rs1_d2 (.slot(d2), .used(id_rs1_used), .addr(id_rs1_addr), .hit(rs1_d2), .load_hit());
    hazard_match u_rs2_d2 (.slot(d2), .used(id_rs2_used), .addr(id_rs2_addr), .hit(rs2_d2), .load_hit());

    always_comb begin
        // A load in EX cannot forward to the ALU yet, so the consumer waits one cycle
        stall   = id_valid & (rs1_ld1 | rs2_ld1) & ~flush;
        advance = id_valid & ~stall & ~flush & ~hold;
        rs1_sel = rs1_d1 ? FWD_ALU : rs1_d2 ? FWD_MEM : FWD_RF;
        rs2_sel = rs2_d1 ? FWD_ALU : rs2_d2 ? FWD_MEM : FWD_RF;
        id_slot = '{valid: 1'b1, rd: id_rd_addr, we: id_rd_we, is_load: id_is_load};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1         <= '0;
            d2         <= '0;
            rs1_hazard <= FWD_RF;
            rs2_hazard <= FWD_RF;
            ex_bubble  <= 1'b1;
        end else if (!hold) begin
            d2         <= d1;
            d1         <= advance ? id_slot : '0;
            rs1_hazard <= advance ? rs1_sel : FWD_RF;
            rs2_hazard <= advance ? rs2_sel : FWD_RF;
            ex_bubble  <= ~advance;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall & ~hold)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst, id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, flush, hold;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [1:0] rs1_hazard, rs2_hazard;
    logic       stall, ex_bubble;
    int         tests = 0;
    int         fails = 0;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .flush(flush), .hold(hold),
        .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
        .stall(stall), .ex_bubble(ex_bubble)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic u1, input logic [4:0] a1,
                         input logic u2, input logic [4:0] a2,
                         input logic we, input logic [4:0] rd, input logic ld);
        id_valid = v; id_rs1_used = u1; id_rs1_addr = a1;
        id_rs2_used = u2; id_rs2_addr = a2;
        id_rd_we = we; id_rd_addr = rd; id_is_load = ld;
        #1;
    endtask

    task automatic idle;
        flush = 0; hold = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick; tick;
    endtask

    task automatic test_reset;
        rst = 1; flush = 0; hold = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        tests++; if (ex_bubble !== 1'b1) begin fails++; $display("FAIL rst_bubble got %b exp 1", ex_bubble); end
        tests++; if ({rs1_hazard, rs2_hazard} !== 4'b0000) begin fails++; $display("FAIL rst_sel got %b%b exp 0000", rs1_hazard, rs2_hazard); end
        rst = 0;
        drive(1, 1, 1, 0, 0, 1, 7, 1);
        tick;
        rst = 1; hold = 1; flush = 1;
        tick;
        tests++; if (ex_bubble !== 1'b1) begin fails++; $display("FAIL rst_over_hold got %b exp 1", ex_bubble); end
        rst = 0; hold = 0; flush = 0;
        drive(1, 0, 0, 1, 7, 1, 8, 0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b exp 0", stall); end
`ifdef HAZARD_PERF_EN
        tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt); end
`endif
        idle;
    endtask

    task automatic test_alu_fwd;
        drive(1, 1, 1, 1, 2, 1, 5, 0);
        tick;
        drive(1, 1, 5, 1, 1, 1, 6, 0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_stall got %b exp 0", stall); end
        tick;
        tests++; if (rs1_hazard !== 2'b01) begin fails++; $display("FAIL alu_rs1 got %b exp 01", rs1_hazard); end
        tests++; if (rs2_hazard !== 2'b00) begin fails++; $display("FAIL alu_rs2 got %b exp 00", rs2_hazard); end
        tests++; if (ex_bubble !== 1'b0) begin fails++; $display("FAIL alu_bubble got %b exp 0", ex_bubble); end
        idle;
    endtask

    task automatic test_load_use;
        drive(1, 1, 1, 0, 0, 1, 7, 1);
        tick;
        drive(1, 1, 0, 1, 7, 1, 8, 0);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %b exp 1", stall); end
        tick;
        tests++; if (ex_bubble !== 1'b1) begin fails++; $display("FAIL lu_bubble got %b exp 1", ex_bubble); end
        tests++; if ({rs1_hazard, rs2_hazard} !== 4'b0000) begin fails++; $display("FAIL lu_sel_bubble got %b%b exp 0000", rs1_hazard, rs2_hazard); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_once got %b exp 0", stall); end
        tick;
        tests++; if (rs2_hazard !== 2'b10) begin fails++; $display("FAIL lu_rs2 got %b exp 10", rs2_hazard); end
        tests++; if (rs1_hazard !== 2'b00) begin fails++; $display("FAIL lu_rs1 got %b exp 00", rs1_hazard); end
        tests++; if (ex_bubble !== 1'b0) begin fails++; $display("FAIL lu_adv got %b exp 0", ex_bubble); end
`ifdef HAZARD_PERF_EN
        tests++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
`endif
        idle;
    endtask

    task automatic test_mem_fwd;
        drive(1, 1, 1, 1, 2, 1, 3, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tests++; if (ex_bubble !== 1'b1) begin fails++; $display("FAIL mem_nop got %b exp 1", ex_bubble); end
        drive(1, 1, 3, 1, 3, 1, 4, 0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mem_stall got %b exp 0", stall); end
        tick;
        tests++; if ({rs1_hazard, rs2_hazard} !== 4'b1010) begin fails++; $display("FAIL mem_sel got %b%b exp 1010", rs1_hazard, rs2_hazard); end
        idle;
    endtask

    task automatic test_x0;
        drive(1, 1, 1, 0, 0, 1, 0, 1);
        tick;
        drive(1, 1, 0, 1, 0, 1, 9, 0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_stall got %b exp 0", stall); end
        tick;
        tests++; if ({rs1_hazard, rs2_hazard} !== 4'b0000) begin fails++; $display("FAIL x0_sel got %b%b exp 0000", rs1_hazard, rs2_hazard); end
        idle;
    endtask

    task automatic test_flush_stall;
        drive(1, 1, 1, 0, 0, 1, 7, 1);
        tick;
        flush = 1;
        drive(1, 1, 7, 1, 7, 1, 8, 0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fl_stall got %b exp 0", stall); end
        tick;
        tests++; if (ex_bubble !== 1'b1) begin fails++; $display("FAIL fl_bubble got %b exp 1", ex_bubble); end
        tests++; if ({rs1_hazard, rs2_hazard} !== 4'b0000) begin fails++; $display("FAIL fl_sel got %b%b exp 0000", rs1_hazard, rs2_hazard); end
        flush = 0;
        idle;
    endtask

    task automatic test_hold;
        drive(1, 1, 1, 1, 2, 1, 5, 0);
        tick;
        drive(1, 1, 5, 1, 5, 1, 6, 0);
        tick;
        tests++; if ({rs1_hazard, rs2_hazard} !== 4'b0101) begin fails++; $display("FAIL hd_pre got %b%b exp 0101", rs1_hazard, rs2_hazard); end
        hold = 1; flush = 1;
        drive(1, 0, 0, 0, 0, 1, 11, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++; if ({rs1_hazard, rs2_hazard, ex_bubble} !== 5'b01010) begin fails++; $display("FAIL hd_frozen[%0d] got %b%b%b exp 01010", i, rs1_hazard, rs2_hazard, ex_bubble); end
        end
        hold = 0; flush = 0;
        drive(1, 1, 6, 1, 5, 1, 12, 0);
        tick;
        tests++; if ({rs1_hazard, rs2_hazard} !== 4'b0110) begin fails++; $display("FAIL hd_slots got %b%b exp 0110", rs1_hazard, rs2_hazard); end
        idle;
        drive(1, 1, 1, 0, 0, 1, 9, 1);
        tick;
        hold = 1;
        drive(1, 1, 9, 0, 0, 1, 10, 0);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hd_stall got %b exp 1", stall); end
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++; if (ex_bubble !== 1'b0) begin fails++; $display("FAIL hd_bubble[%0d] got %b exp 0", i, ex_bubble); end
`ifdef HAZARD_PERF_EN
            tests++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL hd_cnt[%0d] got %0d exp 1", i, stall_cnt); end
`endif
        end
        hold = 0;
        #1;
        tick;
        tests++; if (ex_bubble !== 1'b1) begin fails++; $display("FAIL hd_rel_bubble got %b exp 1", ex_bubble); end
`ifdef HAZARD_PERF_EN
        tests++; if (stall_cnt !== 32'd2) begin fails++; $display("FAIL hd_rel_cnt got %0d exp 2", stall_cnt); end
`endif
        tick;
        tests++; if (rs1_hazard !== 2'b10) begin fails++; $display("FAIL hd_rel_rs1 got %b exp 10", rs1_hazard); end
        idle;
    endtask

    initial begin
        test_reset;
        test_alu_fwd;
        test_load_use;
        test_mem_fwd;
        test_x0;
        test_flush_stall;
        test_hold;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, inputs, 1 each; decode-stage instruction present / operand read / writes rd / is a load.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr, id_rd_addr, inputs, 5 each; decode-stage register indices.
REQ-005 SHALL have port flush, input, 1, branch mispredict; squashes the decode-stage instruction.
REQ-006 SHALL have port hold, input, 1, global pipeline freeze (memory wait).
REQ-007 SHALL have ports rs1_hazard, rs2_hazard, outputs, 2 each, registered forwarding selects for the EX-stage operand muxes: 00 register file, 01 ALU result, 10 memtoreg data; 11 never driven.
REQ-008 SHALL have port stall, output, 1, combinational; holds PC and IF/ID.
REQ-009 SHALL have port ex_bubble, output, 1, registered; EX stage holds no valid instruction.

Function
REQ-010 SHALL track two slots: D1 (instruction now in EX) and D2 (instruction one stage older), each {valid, rd, we, is_load}.
REQ-011 SHALL define advance = id_valid & ~stall & ~flush & ~hold.
REQ-012 On each edge with hold=0: D2<=D1; D1<=decode fields if advance, else bubble (valid=0).
REQ-013 On each edge with hold=1: D1, D2, rs1_hazard, rs2_hazard, ex_bubble SHALL keep their values.
REQ-014 Per operand, registered select with hold=0 and advance=1: 01 if used & D1.valid & D1.we & rd==D1.rd & rd!=0; else 10 if same against D2; else 00 (D1 has priority).
REQ-015 Selects SHALL register 00 whenever advance=0 with hold=0.
REQ-016 stall SHALL be 1 iff id_valid & D1.valid & D1.is_load & D1.we & D1.rd!=0 & ((id_rs1_used & id_rs1_addr==D1.rd) | (id_rs2_used & id_rs2_addr==D1.rd)) & ~flush.
REQ-017 Load-use stall SHALL last exactly one cycle; the stalled instruction then advances with select 10 for the load operand.
REQ-018 flush SHALL take priority over stall; with flush=1, hold=0: D1 becomes bubble, selects register 00, ex_bubble registers 1.
REQ-019 hold SHALL take priority over flush; flush sampled only when hold=0.
REQ-020 ex_bubble SHALL register ~advance when hold=0.
REQ-021 Register x0 SHALL never match any slot.

Reset
REQ-022 With rst=1 at an edge: D1, D2 invalid; rs1_hazard=rs2_hazard=00; ex_bubble=1; overrides hold and flush.
REQ-023 stall SHALL be 0 in the cycle after reset (D1 invalid).

Configuration
REQ-024 With HAZARD_PERF_EN defined: output stall_cnt, 32-bit, counts cycles with stall=1 & hold=0, wraps 0xFFFFFFFF->0, reset to 0.
REQ-025 Without HAZARD_PERF_EN: no stall_cnt port or counter logic; all other behaviour identical.

Structure
REQ-026 Package hazard_pkg SHALL hold FWD_RF=2'b00, FWD_ALU=2'b01, FWD_MEM=2'b10 and the slot record typedef.
REQ-027 Sub-module hazard_match (one slot vs one source index -> hit) SHALL be instantiated per slot per operand.

Verification
REQ-028 add x5 then add x6,x5,x1 back-to-back -> rs1_hazard=01 on the consumer's EX cycle, stall=0.
REQ-029 lw x7 then add x8,x0,x7 -> stall=1 one cycle, ex_bubble=1, then rs2_hazard=10.
REQ-030 add x3; nop; sub x4,x3,x3 -> rs1_hazard=rs2_hazard=10.
REQ-031 Producer writes x0, consumer reads x0 -> selects 00, stall=0.
REQ-032 Load-use stall with flush=1 same cycle -> stall=0, ex_bubble=1, selects 00.
REQ-033 hold=1 for 3 cycles mid-forward -> selects and slots frozen; with HAZARD_PERF_EN, stall_cnt unchanged during hold.
